// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and constants for the VGA raster engine:
//                mode timing struct, standard mode constants, the 24-bit
//                colour type and the colour-bar table used by the optional
//                test pattern (VGA_TESTPAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Packed {R,G,B}, 8 bits per component
    typedef logic [23:0] rgb_t;

    // One axis of a video mode, in pixels (horizontal) or lines (vertical)
    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
    localparam vga_timing_t VGA_640x480_60_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};
    localparam vga_timing_t VGA_640x480_60   = VGA_640x480_60_H;
    localparam vga_timing_t VGA_800x600_72   = '{active: 16'd800, fp: 16'd56, sync: 16'd120, bp: 16'd64};

    // Vertical colour bars, left to right
    localparam rgb_t BAR_COLOURS [8] = '{
        24'hFFFFFF,   // white
        24'hFFFF00,   // yellow
        24'h00FFFF,   // cyan
        24'h00FF00,   // green
        24'hFF00FF,   // magenta
        24'hFF0000,   // red
        24'h0000FF,   // blue
        24'h000000    // black
    };

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Pixel request/response bus between the raster engine
//                (master) and the upstream pixel source (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           req;
    logic [X_W-1:0] req_x;
    logic [Y_W-1:0] req_y;
    rgb_t           rgb_in;
    logic           frame_start;

    modport master (output req, req_x, req_y, frame_start, input rgb_in);
    modport slave  (input req, req_x, req_y, frame_start, output rgb_in);
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : One raster axis: counts 0..TOTAL-1 on ce_i, flags the last
//                position, the active region and the sync window (driven at
//                pin polarity POL).
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         ce_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);
    localparam int           C_TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] C_LAST       = W'(C_TOTAL - 1);
    localparam logic [W-1:0] C_ACTIVE     = W'(ACTIVE);
    localparam logic [W-1:0] C_SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] C_SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // wrap_o marks the last position, whether or not ce_i is high this cycle
    assign wrap_o   = (count_q == C_LAST);
    assign active_o = (count_q < C_ACTIVE);
    assign sync_o   = ((count_q >= C_SYNC_START) && (count_q < C_SYNC_END)) ? POL : ~POL;
    assign count_o  = count_q;

    // Next count: clear wins, otherwise advance and wrap on ce
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (ce_i) begin
            count_d = wrap_o ? '0 : count_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster engine. Divides CLOCK_50 down to the
//                pixel rate, runs h/v counters, requests one pixel per pixel
//                period from the upstream source and registers syncs, blank
//                and colour onto the DAC pins one pixel after the request.
//                Optional macro VGA_TESTPAT_EN adds a test_mode input that
//                replaces upstream data with eight vertical colour bars.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = int'(VGA_640x480_60_H.active),
    parameter int H_FP     = int'(VGA_640x480_60_H.fp),
    parameter int H_SYNC   = int'(VGA_640x480_60_H.sync),
    parameter int H_BP     = int'(VGA_640x480_60_H.bp),
    parameter int V_ACTIVE = int'(VGA_640x480_60_V.active),
    parameter int V_FP     = int'(VGA_640x480_60_V.fp),
    parameter int V_SYNC   = int'(VGA_640x480_60_V.sync),
    parameter int V_BP     = int'(VGA_640x480_60_V.bp),
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             run,
`ifdef VGA_TESTPAT_EN
    input  logic             test_mode,
`endif
    vga_timing_gen_if.master pix_if,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic             VGA_CLK,
    output logic             VGA_SYNC_N,
    output logic             VGA_BLANK_N,
    output logic             VGA_HS,
    output logic             VGA_VS
);
    localparam int                   C_DIV_W    = $clog2(CLK_DIV);
    localparam logic [C_DIV_W-1:0]   C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_DIV_W-1:0]   C_DIV_HALF = C_DIV_W'(CLK_DIV / 2);

    logic [C_DIV_W-1:0] div_q;
    logic [C_DIV_W-1:0] div_d;
    logic               vga_clk_q;
    logic               vga_clk_d;
    logic               hs_q;
    logic               vs_q;
    logic               blank_n_q;
    rgb_t               rgb_q;

    logic               w_pix_ce;
    logic               w_v_ce;
    logic               w_clr;
    logic [X_W-1:0]     w_h_count;
    logic [Y_W-1:0]     w_v_count;
    logic               w_h_wrap;
    logic               w_v_wrap_unused;   // frame boundary is taken from the counts directly
    logic               w_h_active;
    logic               w_v_active;
    logic               w_active;
    logic               w_h_sync;
    logic               w_v_sync;
    logic               w_req;
    rgb_t               w_rgb;

    assign w_clr    = ~run;
    assign w_pix_ce = run & (div_q == C_DIV_LAST);
    assign w_v_ce   = w_pix_ce & w_h_wrap;
    assign w_active = w_h_active & w_v_active;

    // Pixel-rate divider and the pixel clock derived from its next value,
    // so VGA_CLK falls with the output update and rises mid-pixel
    always_comb begin
        div_d     = (w_clr || w_pix_ce) ? '0 : div_q + C_DIV_W'(1);
        vga_clk_d = run & (div_d >= C_DIV_HALF);
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (X_W)
    ) u_h_counter (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .clr_i    (w_clr),
        .ce_i     (w_pix_ce),
        .count_o  (w_h_count),
        .wrap_o   (w_h_wrap),
        .active_o (w_h_active),
        .sync_o   (w_h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (Y_W)
    ) u_v_counter (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .clr_i    (w_clr),
        .ce_i     (w_v_ce),
        .count_o  (w_v_count),
        .wrap_o   (w_v_wrap_unused),
        .active_o (w_v_active),
        .sync_o   (w_v_sync)
    );

`ifdef VGA_TESTPAT_EN
    localparam int C_BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;

    logic [X_W-1:0] w_bar_num;
    logic [2:0]     w_bar_idx;

    // Pixel request and colour source; the bar pattern suppresses requests
    always_comb begin
        w_bar_num = w_h_count / X_W'(C_BAR_W);
        w_bar_idx = (w_bar_num > X_W'(7)) ? 3'd7 : w_bar_num[2:0];
        w_req     = w_pix_ce & w_active & ~test_mode;
        w_rgb     = test_mode ? BAR_COLOURS[w_bar_idx] : pix_if.rgb_in;
    end
`else
    // Pixel request and colour source
    always_comb begin
        w_req = w_pix_ce & w_active;
        w_rgb = pix_if.rgb_in;
    end
`endif

    assign pix_if.req         = w_req;
    assign pix_if.req_x       = w_h_count;
    assign pix_if.req_y       = w_v_count;
    assign pix_if.frame_start = w_pix_ce & (w_h_count == '0) & (w_v_count == '0);

    // Pin registers: updated once per pixel from the current counters,
    // forced to idle levels whenever the raster is stopped
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q     <= '0;
            vga_clk_q <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            div_q     <= div_d;
            vga_clk_q <= vga_clk_d;
            if (!run) begin
                hs_q      <= ~HS_POL;
                vs_q      <= ~VS_POL;
                blank_n_q <= 1'b0;
                rgb_q     <= '0;
            end else if (w_pix_ce) begin
                hs_q      <= w_h_sync;
                vs_q      <= w_v_sync;
                blank_n_q <= w_active;
                rgb_q     <= w_active ? w_rgb : '0;
            end
        end
    end

    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_CLK     = vga_clk_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Small 14x7 mode for
//                raster, data, run/stop and reset cases; a second instance in
//                the default 640x480 mode for pixel-clock and line period.
//                Builds with or without VGA_TESTPAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [23:0] rgb;
        logic        blank_n;
        logic        hs;
        logic        vs;
    } pins_t;

    localparam pins_t RESET_PINS = '{rgb: 24'h0, blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    logic run      = 1'b0;
    logic run2     = 1'b0;
    logic tm       = 1'b0;
    logic tm2      = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_timing_gen_if #(.X_W(8),  .Y_W(8))  pix ();
    vga_timing_gen_if #(.X_W(10), .Y_W(10)) pix2 ();

    logic [7:0] R, G, B, R2, G2, B2;
    logic vclk, sync_n, blank_n, hs, vs;
    logic vclk2, sync_n2, blank_n2, hs2, vs2;
    pins_t act_pins;
    assign act_pins = {R, G, B, blank_n, hs, vs};

    // Upstream source: colour encodes the requested coordinate; in pattern
    // mode a distinctive value that must never reach the pins
    assign pix.rgb_in  = tm ? 24'h5A3C69 : {pix.req_x, pix.req_y, 8'hA5};
    assign pix2.rgb_in = 24'h808080;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .HS_POL(1'b0), .VS_POL(1'b0), .X_W(8), .Y_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .run(run),
`ifdef VGA_TESTPAT_EN
        .test_mode(tm),
`endif
        .pix_if(pix),
        .VGA_R(R), .VGA_G(G), .VGA_B(B), .VGA_CLK(vclk), .VGA_SYNC_N(sync_n),
        .VGA_BLANK_N(blank_n), .VGA_HS(hs), .VGA_VS(vs)
    );

    vga_timing_gen dut2 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .run(run2),
`ifdef VGA_TESTPAT_EN
        .test_mode(tm2),
`endif
        .pix_if(pix2),
        .VGA_R(R2), .VGA_G(G2), .VGA_B(B2), .VGA_CLK(vclk2), .VGA_SYNC_N(sync_n2),
        .VGA_BLANK_N(blank_n2), .VGA_HS(hs2), .VGA_VS(vs2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference raster state as it should be right now (between edges)
    int    m_div = 0;
    int    m_h   = 0;
    int    m_v   = 0;
    logic  exp_clk = 1'b0;
    pins_t exp_pins = RESET_PINS;
    pins_t sb[$];

    function automatic logic [23:0] bar_col(input int k);
        case (k)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // One CLOCK_50 cycle: on a pixel-enable cycle push the pins the DUT must
    // show after the edge, then advance the reference and pop
    task automatic model_tick();
        pins_t e;
        if (run && m_div == 1) begin
            e.blank_n = (m_h < 8) && (m_v < 4);
            e.rgb     = !e.blank_n ? 24'h0 : (tm ? bar_col(m_h) : {8'(m_h), 8'(m_v), 8'hA5});
            e.hs      = !((m_h >= 10) && (m_h < 12));
            e.vs      = !(m_v == 5);
            sb.push_back(e);
        end
        @(posedge CLOCK_50); #1;
        if (!run) begin
            m_div = 0; m_h = 0; m_v = 0;
            exp_clk = 1'b0;
            sb.delete();
            exp_pins = RESET_PINS;
        end else begin
            if (m_div == 1) begin
                m_div = 0;
                if (m_h == 13) begin
                    m_h = 0;
                    m_v = (m_v == 6) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end else begin
                m_div = 1;
            end
            exp_clk = (m_div == 1);
            if (sb.size() > 0) exp_pins = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        #25;
        n_tests++; if (act_pins !== RESET_PINS) begin n_fail++; $display("FAIL reset_pins: got %h want %h", act_pins, RESET_PINS); end
        n_tests++; if ({vclk, sync_n, pix.req, pix.frame_start} !== 4'b0000) begin n_fail++; $display("FAIL reset_misc: got %b want 0000", {vclk, sync_n, pix.req, pix.frame_start}); end
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        repeat (3) model_tick();
        n_tests++; if (act_pins !== RESET_PINS) begin n_fail++; $display("FAIL idle_pins: got %h want %h", act_pins, RESET_PINS); end
        n_tests++; if (pix.frame_start !== 1'b0 || vclk !== 1'b0) begin n_fail++; $display("FAIL idle_misc: fs %b clk %b want 0 0", pix.frame_start, vclk); end
    endtask

    task automatic test_frame_timing();
        int last_fs = -1;
        int fs_cnt = 0;
        int hs_low = 0;
        int vs_low = 0;
        logic exp_fs;
        run = 1'b1;
        for (int c = 0; c < 2 * 196 + 4; c++) begin
            exp_fs = run && (m_div == 1) && (m_h == 0) && (m_v == 0);
            n_tests++; if (pix.frame_start !== exp_fs) begin n_fail++; $display("FAIL frame_start c=%0d: got %b want %b", c, pix.frame_start, exp_fs); end
            n_tests++; if (act_pins !== exp_pins) begin n_fail++; $display("FAIL timing_pins c=%0d: got %h want %h", c, act_pins, exp_pins); end
            n_tests++; if (vclk !== exp_clk) begin n_fail++; $display("FAIL vga_clk c=%0d: got %b want %b", c, vclk, exp_clk); end
            if (pix.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    n_tests++; if (c - last_fs != 196) begin n_fail++; $display("FAIL frame_period: got %0d want 196", c - last_fs); end
                end
                last_fs = c;
                fs_cnt++;
            end
            if (c >= 196 && c < 392) begin
                if (hs === 1'b0) hs_low++;
                if (vs === 1'b0) vs_low++;
            end
            model_tick();
        end
        n_tests++; if (fs_cnt != 3) begin n_fail++; $display("FAIL frame_count: got %0d want 3", fs_cnt); end
        n_tests++; if (hs_low != 28) begin n_fail++; $display("FAIL hs_low_clocks: got %0d want 28", hs_low); end
        n_tests++; if (vs_low != 28) begin n_fail++; $display("FAIL vs_low_clocks: got %0d want 28", vs_low); end
    endtask

    task automatic test_pixel_data();
        logic exp_req;
        logic prev_blank;
        logic tracking = 1'b0;
        int   exp_r = 0;
        prev_blank = blank_n;
        for (int c = 0; c < 196; c++) begin
            exp_req = run && (m_div == 1) && (m_h < 8) && (m_v < 4) && !tm;
            n_tests++; if (pix.req !== exp_req) begin n_fail++; $display("FAIL req c=%0d: got %b want %b", c, pix.req, exp_req); end
            if (exp_req) begin
                n_tests++; if ({pix.req_x, pix.req_y} !== {8'(m_h), 8'(m_v)}) begin n_fail++; $display("FAIL req_xy: got %0d,%0d want %0d,%0d", pix.req_x, pix.req_y, m_h, m_v); end
            end
            n_tests++; if (act_pins !== exp_pins) begin n_fail++; $display("FAIL data_pins c=%0d: got %h want %h", c, act_pins, exp_pins); end
            if (blank_n === 1'b1 && prev_blank === 1'b0) begin tracking = 1'b1; exp_r = 0; end
            if (blank_n === 1'b0) begin
                tracking = 1'b0;
                n_tests++; if ({R, G, B} !== 24'h0) begin n_fail++; $display("FAIL porch_rgb: got %h want 000000", {R, G, B}); end
            end else if (tracking && vclk === 1'b0) begin
                n_tests++; if (R !== 8'(exp_r) || B !== 8'hA5) begin n_fail++; $display("FAIL line_pixel: R %0d B %h want R %0d B a5", R, B, exp_r); end
                exp_r++;
            end
            prev_blank = blank_n;
            model_tick();
        end
    endtask

    task automatic test_run_stop();
        int k;
        bit found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            if (m_h == 5 && m_v == 2) found = 1'b1;
            else model_tick();
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL stop_point: h=5 v=2 not reached, got %0d,%0d", m_h, m_v); end
        n_tests++; if (blank_n !== 1'b1) begin n_fail++; $display("FAIL stop_pre_blank: got %b want 1", blank_n); end
        run = 1'b0;
        #1;
        n_tests++; if (pix.req !== 1'b0) begin n_fail++; $display("FAIL stop_req: got %b want 0", pix.req); end
        model_tick();
        n_tests++; if (act_pins !== {24'h0, 1'b0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL stop_pins: got %h want %h", act_pins, RESET_PINS); end
        n_tests++; if (vclk !== 1'b0) begin n_fail++; $display("FAIL stop_clk: got %b want 0", vclk); end
        model_tick();
        run = 1'b1;
        k = 0;
        while (k < 8 && pix.frame_start !== 1'b1) begin
            model_tick();
            k++;
        end
        // frame_start spans the second edge after run rises
        n_tests++; if (k != 1) begin n_fail++; $display("FAIL restart_fs: got %0d cycles want 1", k); end
        n_tests++; if ({pix.req, pix.req_x, pix.req_y} !== {1'b1, 8'd0, 8'd0}) begin n_fail++; $display("FAIL restart_req: got %b %0d %0d want 1 0 0", pix.req, pix.req_x, pix.req_y); end
        repeat (20) begin
            n_tests++; if (act_pins !== exp_pins) begin n_fail++; $display("FAIL restart_pins: got %h want %h", act_pins, exp_pins); end
            model_tick();
        end
    endtask

    task automatic test_async_reset();
        int c = 0;
        while (c < 400 && !(blank_n === 1'b1 && m_h == 5)) begin
            model_tick();
            c++;
        end
        n_tests++; if (blank_n !== 1'b1) begin n_fail++; $display("FAIL areset_pre: blank got %b want 1", blank_n); end
        #4;
        RESET_N = 1'b0;
        #1;
        n_tests++; if (act_pins !== RESET_PINS) begin n_fail++; $display("FAIL areset_pins: got %h want %h", act_pins, RESET_PINS); end
        n_tests++; if ({vclk, pix.req, pix.frame_start} !== 3'b000) begin n_fail++; $display("FAIL areset_misc: got %b want 000", {vclk, pix.req, pix.frame_start}); end
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        m_div = 0; m_h = 0; m_v = 0;
        exp_clk = 1'b0; exp_pins = RESET_PINS; sb.delete();
        n_tests++; if (pix.frame_start !== 1'b0) begin n_fail++; $display("FAIL areset_fs0: got %b want 0", pix.frame_start); end
        model_tick();
        n_tests++; if ({pix.frame_start, pix.req, pix.req_x, pix.req_y} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin n_fail++; $display("FAIL areset_restart: got %b %b %0d %0d want 1 1 0 0", pix.frame_start, pix.req, pix.req_x, pix.req_y); end
        repeat (30) begin
            n_tests++; if (act_pins !== exp_pins) begin n_fail++; $display("FAIL areset_pins_run: got %h want %h", act_pins, exp_pins); end
            model_tick();
        end
    endtask

    task automatic test_default_mode();
        longint t_rise[2];
        int     n_rise = 0;
        int     hs_fall[2];
        int     n_fall = 0;
        int     hs_rise_c = -1;
        logic   pclk, phs;
        run2 = 1'b1;
        @(posedge CLOCK_50); #1;
        pclk = vclk2; phs = hs2;
        for (int c = 0; c < 4000 && n_fall < 2; c++) begin
            @(posedge CLOCK_50); #1;
            if (vclk2 === 1'b1 && pclk === 1'b0 && n_rise < 2) begin t_rise[n_rise] = $time; n_rise++; end
            if (hs2 === 1'b0 && phs === 1'b1) begin hs_fall[n_fall] = c; n_fall++; end
            if (hs2 === 1'b1 && phs === 1'b0 && n_fall == 1 && hs_rise_c < 0) hs_rise_c = c;
            pclk = vclk2; phs = hs2;
        end
        n_tests++; if (n_rise < 2 || (t_rise[1] - t_rise[0]) != 40) begin n_fail++; $display("FAIL vga_clk_period: got %0d ns (%0d edges) want 40", (n_rise < 2) ? 0 : t_rise[1] - t_rise[0], n_rise); end
        n_tests++; if (n_fall < 2 || (hs_fall[1] - hs_fall[0]) != 1600) begin n_fail++; $display("FAIL hs_period: got %0d clocks (%0d edges) want 1600", (n_fall < 2) ? 0 : hs_fall[1] - hs_fall[0], n_fall); end
        n_tests++; if (n_fall < 1 || hs_rise_c - hs_fall[0] != 192) begin n_fail++; $display("FAIL hs_width: got %0d clocks want 192", (n_fall < 1) ? 0 : hs_rise_c - hs_fall[0]); end
        n_tests++; if (sync_n2 !== 1'b0) begin n_fail++; $display("FAIL sync_n: got %b want 0", sync_n2); end
    endtask

`ifdef VGA_TESTPAT_EN
    task automatic test_pattern();
        logic prev_blank;
        logic tracking = 1'b0;
        int   k = 0;
        tm = 1'b1;
        prev_blank = blank_n;
        for (int c = 0; c < 200; c++) begin
            n_tests++; if (pix.req !== 1'b0) begin n_fail++; $display("FAIL pat_req: got %b want 0", pix.req); end
            n_tests++; if (act_pins !== exp_pins) begin n_fail++; $display("FAIL pat_pins c=%0d: got %h want %h", c, act_pins, exp_pins); end
            if (blank_n === 1'b1 && prev_blank === 1'b0) begin tracking = 1'b1; k = 0; end
            if (blank_n === 1'b0) tracking = 1'b0;
            else if (tracking && vclk === 1'b0) begin
                n_tests++; if ({R, G, B} !== bar_col(k)) begin n_fail++; $display("FAIL bar x=%0d: got %h want %h", k, {R, G, B}, bar_col(k)); end
                k++;
            end
            prev_blank = blank_n;
            model_tick();
        end
        tm = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame_timing();
        test_pixel_data();
        test_run_stop();
        test_async_reset();
`ifdef VGA_TESTPAT_EN
        test_pattern();
`endif
        test_default_mode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster engine driven from CLOCK_50; successor to the fixed 640x480 VGA test design.
- Generates the pixel clock, HS/VS, blank and pixel coordinates for any mode through parameters.
- Issues a per-pixel request to an upstream pixel source and registers the returned RGB onto the VGA DAC pins.
- Sits between the frame/pixel source and the board VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, CLOCK_50 cycles per pixel; must be >=2
- HS_POL, 0, HS active level (0 = active-low)
- VS_POL, 0, VS active level (0 = active-low)
- X_W, 10, width of x counter/coordinate; must hold H_TOTAL-1
- Y_W, 10, width of y counter/coordinate; must hold V_TOTAL-1

Ports:
- CLOCK_50  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- run  in  1  1 = raster running; 0 = counters held at origin
- req  out  1  combinational; high in active region on pix_ce cycles
- req_x  out  X_W  coordinate of requested pixel
- req_y  out  Y_W  coordinate of requested pixel
- rgb_in  in  24  {R,G,B}; sampled on the CLOCK_50 edge where req=1
- frame_start  out  1  one-CLOCK_50 pulse at h=0,v=0 on pix_ce
- VGA_R / VGA_G / VGA_B  out  8 each  registered colour
- VGA_CLK  out  1  pixel clock
- VGA_SYNC_N  out  1  tied 0
- VGA_BLANK_N  out  1  registered; 1 in active region
- VGA_HS / VGA_VS  out  1  registered syncs

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- div counter: runs 0..CLK_DIV-1. pix_ce = (div == CLK_DIV-1).
- VGA_CLK: registered; 1 when div >= CLK_DIV/2. Its rising edge is centred on stable outputs.
- h counter: advances on pix_ce and wraps H_TOTAL-1 -> 0.
- v counter: advances on pix_ce only when h wraps; wraps V_TOTAL-1 -> 0.
- Active region: h < H_ACTIVE and v < V_ACTIVE. req_x = h, req_y = v.
- HS: asserted (level HS_POL) for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- VS: asserted (level VS_POL) for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. VS ignores h.
- Output latency: on each pix_ce, HS, VS, BLANK_N and RGB are registered from the current h/v.
  - Outputs therefore lag the counters by exactly one pixel period; all pins are aligned with each other.
  - RGB = rgb_in when active, else 0.
- Reset (RESET_N=0, async):
  - div, h, v = 0.
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL (inactive levels).
  - VGA_BLANK_N = 0, RGB = 0, VGA_CLK = 0, req = 0, frame_start = 0.
- run=0, including mid-frame: synchronously returns div/h/v to 0 and forces all outputs to their reset values on the next edge.
  - On run 0->1, the first pix_ce after CLK_DIV cycles produces frame_start and req for (0,0).
- frame_start: high only on the pix_ce cycle with h=0, v=0, run=1.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- When defined:
  - Adds port test_mode (in, 1).
  - With test_mode=1, rgb_in is ignored and req stays 0.
  - RGB shows 8 vertical colour bars of width H_ACTIVE/8, in order: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
- When undefined: no test_mode port and no pattern logic; behaviour is exactly as above.

Decomposition:
- Package vga_pkg holds:
  - the timing struct typedef (active/fp/sync/bp);
  - constants VGA_640x480_60 and VGA_800x600_72;
  - the bar colour constant array;
  - the 24-bit rgb_t typedef.
- One natural sub-module, vga_axis_counter: parametrised (ACTIVE, FP, SYNC, BP, POL) counter emitting count, wrap, active and sync.
  - Instantiated twice: horizontal with ce = pix_ce; vertical with ce = pix_ce & h_wrap.

Test Plan:
- Bench parameters for all small-mode cases: H 8/2/2/2, V 4/1/1/1, CLK_DIV=2; totals 14 x 7 = 196 clocks per frame.
- Reset then run=1 -> frame_start every 196 clocks; HS low for 4 clocks starting at h=10 (+1 pixel latency); VS low for 28 clocks starting at v=5.
- rgb_in = {req_x, req_y, 8'hA5} -> VGA_R at first visible output = 0, increments per pixel to 7; RGB = 0 and BLANK_N = 0 during porches.
- run deasserted at h=5, v=2 -> next edge: HS=1, VS=1, BLANK_N=0, RGB=0; re-assert -> frame_start 2 clocks later.
- RESET_N pulsed low mid-line, asynchronous to the clock edge -> outputs go to reset values without waiting for an edge; counters restart at 0.
- Default 640x480, CLK_DIV=2 -> VGA_CLK period 40 ns; frame period 840000 clocks (16.8 ms); HS period 1600 clocks.
- VGA_TESTPAT_EN defined, test_mode=1, small mode -> bar k at x=k gives R,G,B per table (x=0 white FFFFFF, x=5 red FF0000); req stays 0.
